// File: rtl/reg_file_16x24.sv
// ---------------------------------------------------------------------------
// reg_file_16x24
// Architectural register file for the 24-bit single-cycle CPU datapath.
// Sits downstream of the rt/rd destination-select mux.
// Register 0 is hardwired to zero. Registers 1..15 are flip-flops.
//
// Parameters
//   DATA_W    register / data-port width
//   ADDR_W    address width (depth = 2**ADDR_W)
//   BYPASS    1: forward a same-cycle write to a matching read port
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-low clear of all registers
//   ReadAddr1  in   read port 1 address (rs)
//   ReadAddr2  in   read port 2 address (rt)
//   WriteAddr  in   write address from destination-select mux
//   WriteData  in   write data (ALU result or load data)
//   RegWrite   in   write enable
//   ReadData1  out  combinational read data, port 1
//   ReadData2  out  combinational read data, port 2
// ---------------------------------------------------------------------------
module reg_file_16x24 #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 has no storage at all; reads of address 0 are forced to zero
    // in the read muxes below.
    logic [DATA_W-1:0] regs_reg [1:DEPTH-1];

    // A write is only meaningful for a nonzero address.
    logic wr_valid;
    assign wr_valid = RegWrite && (WriteAddr != '0);

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
            localparam logic [ADDR_W-1:0] ENTRY_ADDR = ADDR_W'(gi);

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    regs_reg[gi] <= '0;
                end else if (wr_valid && (WriteAddr == ENTRY_ADDR)) begin
                    regs_reg[gi] <= WriteData;
                end
            end
        end
    endgenerate

    // Read muxes. Outputs are held at zero while Reset is low so that the
    // bypass path cannot leak WriteData during reset.
    logic bypass_en;
    assign bypass_en = (BYPASS != 0) && Reset && wr_valid;

    always_comb begin
        ReadData1 = '0;
        if (Reset && (ReadAddr1 != '0)) begin
            ReadData1 = regs_reg[ReadAddr1];
            if (bypass_en && (WriteAddr == ReadAddr1)) begin
                ReadData1 = WriteData;
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (Reset && (ReadAddr2 != '0)) begin
            ReadData2 = regs_reg[ReadAddr2];
            if (bypass_en && (WriteAddr == ReadAddr2)) begin
                ReadData2 = WriteData;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_16x24.sv
// ---------------------------------------------------------------------------
// tb_reg_file_16x24
// Directed self-checking bench. Two instances share all inputs:
// u_dut0 stores-only reads (BYPASS=0), u_dut1 forwards writes (BYPASS=1).
// ---------------------------------------------------------------------------
module tb_reg_file_16x24;

    logic        clk;
    logic        rst_n;
    logic [3:0]  raddr1;
    logic [3:0]  raddr2;
    logic [3:0]  waddr;
    logic [23:0] wdata;
    logic        we;
    logic [23:0] rd1_0, rd2_0, rd1_1, rd2_1;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_mem [16];

    reg_file_16x24 #(.DATA_W(24), .ADDR_W(4), .BYPASS(0)) u_dut0 (
        .Clock     (clk),
        .Reset     (rst_n),
        .ReadAddr1 (raddr1),
        .ReadAddr2 (raddr2),
        .WriteAddr (waddr),
        .WriteData (wdata),
        .RegWrite  (we),
        .ReadData1 (rd1_0),
        .ReadData2 (rd2_0)
    );

    reg_file_16x24 #(.DATA_W(24), .ADDR_W(4), .BYPASS(1)) u_dut1 (
        .Clock     (clk),
        .Reset     (rst_n),
        .ReadAddr1 (raddr1),
        .ReadAddr2 (raddr2),
        .WriteAddr (waddr),
        .WriteData (wdata),
        .RegWrite  (we),
        .ReadData1 (rd1_1),
        .ReadData2 (rd2_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
        end else begin
            $display("ok   %s got=%06h", tag, got);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        raddr1 = '0;
        raddr2 = '0;
        waddr  = '0;
        wdata  = '0;
        we     = 1'b0;

        // Reset held with writes hammering: nothing may stick.
        for (int i = 0; i < 6; i++) begin
            we    = i[0];
            waddr = 4'(i + 1);
            wdata = 24'($urandom);
            tick();
        end
        // Read every address on both ports; bypass instance sees a matching
        // live write on port 1 and must still return 0.
        we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raddr1 = 4'(i);
            raddr2 = 4'(15 - i);
            waddr  = 4'(i);
            wdata  = 24'hC0FFEE;
            #1;
            check($sformatf("rst_rd1_b0_a%0d", i), rd1_0, 24'h0);
            check($sformatf("rst_rd2_b0_a%0d", 15 - i), rd2_0, 24'h0);
            check($sformatf("rst_rd1_b1_a%0d", i), rd1_1, 24'h0);
            check($sformatf("rst_rd2_b1_a%0d", 15 - i), rd2_1, 24'h0);
        end

        // Release reset mid-cycle with writes off.
        we    = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        raddr1 = 4'd5;
        raddr2 = 4'd9;
        #1;
        check("post_rst_a5", rd1_0, 24'h0);
        check("post_rst_a9", rd2_1, 24'h0);

        // Basic write/read.
        we = 1'b1; waddr = 4'd5; wdata = 24'hABCDEF;
        tick();
        we = 1'b0; raddr1 = 4'd5; raddr2 = 4'd5; wdata = 24'h123456;
        #1;
        check("wr5_rd1_b0", rd1_0, 24'hABCDEF);
        check("wr5_rd2_b0", rd2_0, 24'hABCDEF);
        check("wr5_rd1_b1", rd1_1, 24'hABCDEF);
        check("wr5_rd2_b1", rd2_1, 24'hABCDEF);
        tick();
        check("nowe_a5_b0", rd1_0, 24'hABCDEF);
        check("nowe_a5_b1", rd2_1, 24'hABCDEF);

        // Register 0 ignores writes and is never bypassed.
        we = 1'b1; waddr = 4'd0; wdata = 24'hFFFFFF; raddr1 = 4'd0;
        #1;
        check("zero_byp_b1", rd1_1, 24'h0);
        tick();
        we = 1'b0;
        #1;
        check("zero_rd_b0", rd1_0, 24'h0);
        check("zero_rd_b1", rd1_1, 24'h0);

        // Read-during-write on entry 3.
        we = 1'b1; waddr = 4'd3; wdata = 24'h000011;
        tick();
        wdata = 24'h000022; raddr2 = 4'd3;
        #1;
        check("rdw_pre_b0", rd2_0, 24'h000011);
        check("rdw_pre_b1", rd2_1, 24'h000022);
        tick();
        we = 1'b0; wdata = 24'h000033;
        #1;
        check("rdw_post_b0", rd2_0, 24'h000022);
        check("rdw_post_b1", rd2_1, 24'h000022);

        // Async reset between edges clears without a clock.
        we = 1'b1; waddr = 4'd15; wdata = 24'h555555;
        tick();
        we = 1'b0; raddr1 = 4'd15;
        #1;
        check("wr15_b0", rd1_0, 24'h555555);
        check("wr15_b1", rd1_1, 24'h555555);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_clr_b0", rd1_0, 24'h0);
        check("async_clr_b1", rd1_1, 24'h0);
        // Write presented during reset is dropped.
        we = 1'b1; waddr = 4'd15; wdata = 24'h777777;
        tick();
        tick();
        // Release mid-cycle with the first sweep write already set up, so the
        // very first edge after release must perform it.
        waddr = 4'd1; wdata = {8'd1, 8'h5A, 8'd1};
        rst_n = 1'b1;
        #1;
        check("lost_wr15_b0", rd1_0, 24'h0);

        // Sweep entries 1..15 on consecutive edges.
        exp_mem[0] = 24'h0;
        for (int i = 1; i < 16; i++) begin
            waddr = 4'(i);
            wdata = {8'(i), 8'h5A, 8'(i)};
            exp_mem[i] = {8'(i), 8'h5A, 8'(i)};
            tick();
        end
        we = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            raddr1 = 4'(i);
            raddr2 = 4'((i * 7) % 16);
            #1;
            check($sformatf("sweep_rd1_b0_a%0d", i), rd1_0, exp_mem[i]);
            check($sformatf("sweep_rd2_b0_a%0d", (i * 7) % 16), rd2_0, exp_mem[(i * 7) % 16]);
            check($sformatf("sweep_rd1_b1_a%0d", i), rd1_1, exp_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
